// File: rtl/coherence_control.sv
// rtl/coherence_control.sv - dual-core snooping coherence controller and single-port RAM arbiter
// Serves dcache/icache requests from two cores, snoops the peer dcache, and queues write-upgrade invalidates.
module coherence_control #(
    parameter int INV_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [1:0]  cctrans,
    input  logic [1:0]  ccwrite,
    input  logic [31:0] daddr [1:0],
    input  logic [31:0] dstore [1:0],
    output logic [1:0]  dwait,
    output logic [31:0] dload [1:0],
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [31:0] ccsnoopaddr [1:0],
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr [1:0],
    output logic [1:0]  iwait,
    output logic [31:0] iload [1:0],
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        inv_overflow
);
    localparam int PW = (INV_DEPTH > 1) ? $clog2(INV_DEPTH) : 1;
    localparam int CW = $clog2(INV_DEPTH + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_CCWB, S_DONE_SNOOP, S_XFER, S_IXFER} state_t;

    state_t        r_state, w_state_n;
    logic          r_core, w_core_n;
    logic          r_is_inv, w_is_inv_n;
    logic [31:0]   r_addr, w_addr_n;
    logic          r_word, w_word_n;
    logic          r_rr, w_rr_n;
    logic          r_inv_rr, w_inv_rr_n;
    logic          r_i_rr, w_i_rr_n;
    logic          r_overflow;
    logic [PW-1:0] r_wp [1:0];
    logic [PW-1:0] r_rp [1:0];
    logic [CW-1:0] r_cnt [1:0];
    logic [31:0]   r_mem [1:0][INV_DEPTH];

    logic       w_peer, w_access, w_sel, w_snoop_ack;
    logic [1:0] w_inv, w_full, w_inv_req, w_d_req, w_busrd, w_pop;

    function automatic logic pick(input logic [1:0] req, input logic rr);
        return (req == 2'b11) ? rr : req[1];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(INV_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_peer   = ~r_core;
    assign w_access = (ramstate == RAM_ACCESS);
    assign inv_overflow = r_overflow;

    // The peer's snoop response looks like an INV pulse, so it is not captured.
    assign w_inv[0] = cctrans[0] & ~dREN[0] & ~dWEN[0] & ~((r_state == S_SNOOP) & r_core);
    assign w_inv[1] = cctrans[1] & ~dREN[1] & ~dWEN[1] & ~((r_state == S_SNOOP) & ~r_core);

    assign w_full[0]    = (r_cnt[0] == CW'(INV_DEPTH));
    assign w_full[1]    = (r_cnt[1] == CW'(INV_DEPTH));
    assign w_inv_req[0] = (r_cnt[0] != '0) | w_inv[0];
    assign w_inv_req[1] = (r_cnt[1] != '0) | w_inv[1];
    assign w_busrd      = cctrans & dREN;
    assign w_d_req      = w_busrd | (dWEN & ccwrite);
    assign w_snoop_ack  = cctrans[w_peer] & ~dREN[w_peer] & ~dWEN[w_peer];

    always_comb begin
        w_state_n  = r_state;
        w_core_n   = r_core;
        w_is_inv_n = r_is_inv;
        w_addr_n   = r_addr;
        w_word_n   = r_word;
        w_rr_n     = r_rr;
        w_inv_rr_n = r_inv_rr;
        w_i_rr_n   = r_i_rr;
        w_pop      = '0;
        w_sel      = 1'b0;
        dwait      = 2'b11;
        iwait      = 2'b11;
        dload[0]   = '0;
        dload[1]   = '0;
        iload[0]   = '0;
        iload[1]   = '0;
        ccwait     = '0;
        ccinv      = '0;
        ccsnoopaddr[0] = '0;
        ccsnoopaddr[1] = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (r_state)
            S_IDLE: begin
                w_word_n = 1'b0;
                if (|w_inv_req) begin
                    w_sel      = pick(w_inv_req, r_inv_rr);
                    w_core_n   = w_sel;
                    w_is_inv_n = 1'b1;
                    // An INV arriving this cycle is pushed at this edge and sits at the head.
                    w_addr_n   = (r_cnt[w_sel] != '0) ? r_mem[w_sel][r_rp[w_sel]] : daddr[w_sel];
                    w_inv_rr_n = ~w_sel;
                    w_state_n  = S_SNOOP;
                end else if (|w_d_req) begin
                    w_sel      = pick(w_d_req, r_rr);
                    w_core_n   = w_sel;
                    w_is_inv_n = 1'b0;
                    w_addr_n   = daddr[w_sel];
                    w_rr_n     = ~w_sel;
                    w_state_n  = w_busrd[w_sel] ? S_SNOOP : S_XFER;
                end else if (|iREN) begin
                    w_sel     = pick(iREN, r_i_rr);
                    w_core_n  = w_sel;
                    w_i_rr_n  = ~w_sel;
                    w_state_n = S_IXFER;
                end
            end
            S_SNOOP: begin
                ccwait[w_peer]      = 1'b1;
                ccinv[w_peer]       = r_is_inv;
                ccsnoopaddr[w_peer] = r_addr;
                if (w_snoop_ack)
                    w_state_n = ccwrite[w_peer] ? S_CCWB : S_DONE_SNOOP;
            end
            S_CCWB: begin
                ccsnoopaddr[w_peer] = r_addr;
                ramWEN   = dWEN[w_peer];
                ramaddr  = daddr[w_peer];
                ramstore = dstore[w_peer];
                if (w_access) begin
                    dwait[w_peer] = 1'b0;
                    w_word_n      = ~r_word;
                    if (r_word) w_state_n = S_DONE_SNOOP;
                end
            end
            S_DONE_SNOOP: begin
                w_word_n = 1'b0;
                if (r_is_inv) begin
                    w_pop[r_core] = 1'b1;
                    w_state_n     = S_IDLE;
                end else begin
                    w_state_n = S_XFER;
                end
            end
            S_XFER: begin
                ramREN   = dREN[r_core];
                ramWEN   = dWEN[r_core];
                ramaddr  = daddr[r_core];
                ramstore = dstore[r_core];
                if (w_access) begin
                    dwait[r_core] = 1'b0;
                    dload[r_core] = ramload;
                    w_word_n      = ~r_word;
                    if (r_word) w_state_n = S_IDLE;
                end
            end
            S_IXFER: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[r_core];
                if (w_access) begin
                    iwait[r_core] = 1'b0;
                    iload[r_core] = ramload;
                    w_state_n     = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_core     <= 1'b0;
            r_is_inv   <= 1'b0;
            r_addr     <= '0;
            r_word     <= 1'b0;
            r_rr       <= 1'b0;
            r_inv_rr   <= 1'b0;
            r_i_rr     <= 1'b0;
            r_overflow <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_wp[k]  <= '0;
                r_rp[k]  <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            r_state  <= w_state_n;
            r_core   <= w_core_n;
            r_is_inv <= w_is_inv_n;
            r_addr   <= w_addr_n;
            r_word   <= w_word_n;
            r_rr     <= w_rr_n;
            r_inv_rr <= w_inv_rr_n;
            r_i_rr   <= w_i_rr_n;
            for (int k = 0; k < 2; k++) begin
                if (w_inv[k]) r_wp[k] <= ptr_inc(r_wp[k]);
                // A push into a full FIFO overwrites the oldest slot, so the read pointer moves too.
                if (w_pop[k] || (w_inv[k] && w_full[k])) r_rp[k] <= ptr_inc(r_rp[k]);
                if (w_inv[k] && !w_pop[k] && !w_full[k]) r_cnt[k] <= r_cnt[k] + 1'b1;
                else if (w_pop[k] && !w_inv[k]) r_cnt[k] <= r_cnt[k] - 1'b1;
                if (w_inv[k] && w_full[k] && !w_pop[k]) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 2; k++)
            if (w_inv[k]) r_mem[k][r_wp[k]] <= daddr[k];
    end
endmodule

// File: tb/tb_coherence_control.sv
// tb/tb_coherence_control.sv - directed self-checking bench for coherence_control
module tb_coherence_control;
    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  dREN, dWEN, cctrans, ccwrite, iREN;
    logic [31:0] daddr [1:0];
    logic [31:0] dstore [1:0];
    logic [31:0] iaddr [1:0];
    logic [1:0]  dwait, ccwait, ccinv, iwait;
    logic [31:0] dload [1:0];
    logic [31:0] ccsnoopaddr [1:0];
    logic [31:0] iload [1:0];
    logic        ramREN, ramWEN, inv_overflow;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_err = 0;

    coherence_control #(.INV_DEPTH(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
        .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .inv_overflow(inv_overflow)
    );

    always #5 CLK = ~CLK;

    // RAM: LAT busy cycles then one ACCESS; unwritten words read as 0xA500_0000 | addr.
    logic [31:0]   mem [0:1023];
    logic [1023:0] wvalid;
    logic          mem_clr;
    int            lat_cnt;

    assign ramstate = (ramREN | ramWEN) ? ((lat_cnt == LAT) ? 2'd2 : 2'd1) : 2'd0;
    assign ramload  = wvalid[ramaddr[11:2]] ? mem[ramaddr[11:2]] : (32'hA500_0000 | {20'h0, ramaddr[11:0]});

    always @(posedge CLK) begin
        if (mem_clr) begin
            wvalid  <= '0;
            lat_cnt <= 0;
        end else if (ramREN | ramWEN) begin
            if (lat_cnt == LAT) begin
                lat_cnt <= 0;
                if (ramWEN) begin
                    mem[ramaddr[11:2]]    <= ramstore;
                    wvalid[ramaddr[11:2]] <= 1'b1;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cc(input int c, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (ccwait[c]) begin hit = 1'b1; break; end
        end
        chk({tag, " ccwait seen"}, 32'(hit), 1);
    endtask

    task automatic wait_dw(input int c, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!dwait[c]) begin hit = 1'b1; break; end
        end
        chk({tag, " dwait low"}, 32'(hit), 1);
    endtask

    task automatic wait_iw(input int c, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!iwait[c]) begin hit = 1'b1; break; end
        end
        chk({tag, " iwait low"}, 32'(hit), 1);
    endtask

    task automatic respond(input int c, input logic dirty);
        cctrans[c] = 1'b1;
        ccwrite[c] = dirty;
        dREN[c]    = 1'b0;
        dWEN[c]    = 1'b0;
        step();
        cctrans[c] = 1'b0;
    endtask

    task automatic no_snoop(input int c, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ccwait[c]) seen = 1'b1;
        end
        chk(tag, 32'(seen), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        nRST = 1'b0; mem_clr = 1'b1;
        dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; iREN = '0;
        for (int k = 0; k < 2; k++) begin
            daddr[k] = '0; dstore[k] = '0; iaddr[k] = '0;
        end
        step(); step();
        @(negedge CLK);
        chk("rst dwait", 32'(dwait), 32'h3);
        chk("rst iwait", 32'(iwait), 32'h3);
        chk("rst ccwait", 32'(ccwait), 0);
        chk("rst ram", {30'h0, ramREN, ramWEN}, 0);
        chk("rst ramaddr", ramaddr, 0);
        chk("rst ovf", 32'(inv_overflow), 0);
        step();
        mem_clr = 1'b0; nRST = 1'b1;
        step();

        // Clean read miss
        cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100;
        wait_cc(1, "t1");
        chk("t1 snoopaddr", ccsnoopaddr[1], 32'h100);
        chk("t1 ccinv", 32'(ccinv[1]), 0);
        chk("t1 ccwait self", 32'(ccwait[0]), 0);
        chk("t1 dwait held", 32'(dwait[0]), 1);
        step(); respond(1, 1'b0);
        wait_dw(0, "t1 w0"); chk("t1 dload0", dload[0], 32'hA500_0100);
        step(); daddr[0] = 32'h104;
        wait_dw(0, "t1 w1"); chk("t1 dload1", dload[0], 32'hA500_0104);
        step(); dREN[0] = 1'b0; cctrans[0] = 1'b0;

        // Dirty peer
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h200;
        wait_cc(0, "t2");
        chk("t2 snoopaddr", ccsnoopaddr[0], 32'h200);
        step(); respond(0, 1'b1);
        dWEN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'hDEAD_0200;
        wait_dw(0, "t2 wb0");
        chk("t2 ramWEN", 32'(ramWEN), 1);
        chk("t2 ramaddr0", ramaddr, 32'h200);
        chk("t2 ramstore0", ramstore, 32'hDEAD_0200);
        chk("t2 snoopaddr wb0", ccsnoopaddr[0], 32'h200);
        chk("t2 ccwait dropped", 32'(ccwait[0]), 0);
        step(); daddr[0] = 32'h204; dstore[0] = 32'hBEEF_0204;
        wait_dw(0, "t2 wb1");
        chk("t2 ramaddr1", ramaddr, 32'h204);
        chk("t2 ramstore1", ramstore, 32'hBEEF_0204);
        chk("t2 snoopaddr wb1", ccsnoopaddr[0], 32'h200);
        step(); dWEN[0] = 1'b0; ccwrite[0] = 1'b0;
        wait_dw(1, "t2 rd0"); chk("t2 dload0", dload[1], 32'hDEAD_0200);
        step(); daddr[1] = 32'h204;
        wait_dw(1, "t2 rd1"); chk("t2 dload1", dload[1], 32'hBEEF_0204);
        step(); dREN[1] = 1'b0; cctrans[1] = 1'b0;

        // Write upgrade
        cctrans[0] = 1'b1; daddr[0] = 32'h300;
        step(); cctrans[0] = 1'b0;
        wait_cc(1, "t3");
        chk("t3 ccinv", 32'(ccinv[1]), 1);
        chk("t3 snoopaddr", ccsnoopaddr[1], 32'h300);
        chk("t3 no ram", {30'h0, ramREN, ramWEN}, 0);
        step(); respond(1, 1'b0);
        no_snoop(1, "t3 fifo empty");

        // Contention: both WB, rr=0, icache waits
        dWEN = 2'b11; ccwrite = 2'b11;
        daddr[0] = 32'h500; dstore[0] = 32'h1111_0500;
        daddr[1] = 32'h600; dstore[1] = 32'h2222_0600;
        iREN[0] = 1'b1; iaddr[0] = 32'h400;
        wait_dw(0, "t4 c0w0");
        chk("t4 ramaddr c0", ramaddr, 32'h500);
        chk("t4 ramstore c0", ramstore, 32'h1111_0500);
        chk("t4 c1 held", 32'(dwait[1]), 1);
        chk("t4 i held a", 32'(iwait[0]), 1);
        step(); daddr[0] = 32'h504;
        wait_dw(0, "t4 c0w1"); chk("t4 ramaddr c0b", ramaddr, 32'h504);
        step(); dWEN[0] = 1'b0; ccwrite[0] = 1'b0;
        wait_dw(1, "t4 c1w0");
        chk("t4 ramaddr c1", ramaddr, 32'h600);
        chk("t4 i held b", 32'(iwait[0]), 1);
        step(); daddr[1] = 32'h604;
        wait_dw(1, "t4 c1w1");
        chk("t4 ramaddr c1b", ramaddr, 32'h604);
        chk("t4 i held c", 32'(iwait[0]), 1);
        step(); dWEN[1] = 1'b0; ccwrite[1] = 1'b0;
        wait_iw(0, "t4 ird"); chk("t4 iload", iload[0], 32'hA500_0400);
        step(); iREN[0] = 1'b0;

        // Invalidate overflow during a core1 BUSRD
        cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h700;
        wait_cc(0, "t5");
        chk("t5 snoopaddr", ccsnoopaddr[0], 32'h700);
        step(); respond(0, 1'b0);
        cctrans[0] = 1'b1; daddr[0] = 32'h800; step();
        daddr[0] = 32'h900; step();
        daddr[0] = 32'hA00; step();
        cctrans[0] = 1'b0;
        chk("t5 overflow", 32'(inv_overflow), 1);
        wait_dw(1, "t5 rd0"); chk("t5 dload0", dload[1], 32'hA500_0700);
        step(); daddr[1] = 32'h704;
        wait_dw(1, "t5 rd1"); chk("t5 dload1", dload[1], 32'hA500_0704);
        step(); dREN[1] = 1'b0; cctrans[1] = 1'b0;
        wait_cc(1, "t5 inv a");
        chk("t5 inv a addr", ccsnoopaddr[1], 32'h900);
        chk("t5 inv a ccinv", 32'(ccinv[1]), 1);
        step(); respond(1, 1'b0);
        wait_cc(1, "t5 inv b");
        chk("t5 inv b addr", ccsnoopaddr[1], 32'hA00);
        step(); respond(1, 1'b0);
        no_snoop(1, "t5 fifo drained");

        // Reset mid-XFER
        cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100;
        wait_cc(1, "t6");
        step(); respond(1, 1'b0);
        step();
        @(negedge CLK);
        chk("t6 in xfer", 32'(ramREN), 1);
        #1 nRST = 1'b0;
        #1;
        chk("t6 dwait", 32'(dwait), 32'h3);
        chk("t6 iwait", 32'(iwait), 32'h3);
        chk("t6 ram", {30'h0, ramREN, ramWEN}, 0);
        chk("t6 ramaddr", ramaddr, 0);
        chk("t6 ccwait", 32'(ccwait), 0);
        chk("t6 dload", dload[0], 0);
        chk("t6 ovf cleared", 32'(inv_overflow), 0);
        dREN[0] = 1'b0; cctrans[0] = 1'b0;
        step(); step();
        nRST = 1'b1;
        step();
        iREN[1] = 1'b1; iaddr[1] = 32'h40;
        wait_iw(1, "t6 ird"); chk("t6 iload", iload[1], 32'hA500_0040);
        step(); iREN[1] = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
